spu_issue_stage: RTL

Dual-issue in-order dispatcher for the SPU. It takes decoded instruction pairs from decode and routes each instruction to the even or odd pipe. It blocks source hazards with a per-register latency scoreboard. It drives the `rf_*` instruction fields that the register-fetch stage of the SPU top level registers on every clock, so it is the producing end of that interface.

---
 rtl/spu_issue_stage_if.sv | 33 +++
 rtl/spu_issue_stage.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/spu_issue_stage_if.sv
// Decode-to-issue handshake bundle: one instruction pair per transfer.
// A pair moves on the clock edge where in_valid and in_ready are both high; decode holds the pair stable while in_valid is high and in_ready is low.
interface spu_issue_stage_if #(
    parameter int REG_ADDR_WIDTH       = 7,
    parameter int INTERNAL_OPCODE_SIZE = 11,
    parameter int LAT_W                = 3
);
    logic                            in_valid;
    logic                            in_ready;
    logic                            s0_pipe,   s1_pipe;
    logic [INTERNAL_OPCODE_SIZE-1:0] s0_opcode, s1_opcode;
    logic [REG_ADDR_WIDTH-1:0]       s0_ra,     s1_ra;
    logic [REG_ADDR_WIDTH-1:0]       s0_rb,     s1_rb;
    logic [REG_ADDR_WIDTH-1:0]       s0_rc,     s1_rc;
    logic [REG_ADDR_WIDTH-1:0]       s0_rt,     s1_rt;
    logic [2:0]                      s0_use,    s1_use;
    logic                            s0_rt_we,  s1_rt_we;
    logic [LAT_W-1:0]                s0_lat,    s1_lat;

    modport master (
        output in_valid,
        output s0_pipe, s0_opcode, s0_ra, s0_rb, s0_rc, s0_rt, s0_use, s0_rt_we, s0_lat,
        output s1_pipe, s1_opcode, s1_ra, s1_rb, s1_rc, s1_rt, s1_use, s1_rt_we, s1_lat,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  s0_pipe, s0_opcode, s0_ra, s0_rb, s0_rc, s0_rt, s0_use, s0_rt_we, s0_lat,
        input  s1_pipe, s1_opcode, s1_ra, s1_rb, s1_rc, s1_rt, s1_use, s1_rt_we, s1_lat,
        output in_ready
    );
endinterface

// File: rtl/spu_issue_stage.sv
// SPU dual-pipe in-order issue stage with per-register latency scoreboard.
// Define SPU_DUAL_ISSUE_EN to allow slot 0 and slot 1 to issue in the same cycle.
module spu_issue_stage #(
    parameter int REG_ADDR_WIDTH       = 7,
    parameter int INTERNAL_OPCODE_SIZE = 11,
    parameter int LAT_W                = 3
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    spu_issue_stage_if.slave                dec,
    output logic [INTERNAL_OPCODE_SIZE-1:0] rf_opcode_even,
    output logic [INTERNAL_OPCODE_SIZE-1:0] rf_opcode_odd,
    output logic [REG_ADDR_WIDTH-1:0]       addr_ra_rd_even,
    output logic [REG_ADDR_WIDTH-1:0]       addr_ra_rd_odd,
    output logic [REG_ADDR_WIDTH-1:0]       addr_rb_rd_even,
    output logic [REG_ADDR_WIDTH-1:0]       addr_rb_rd_odd,
    output logic [REG_ADDR_WIDTH-1:0]       addr_rc_rd_even,
    output logic [REG_ADDR_WIDTH-1:0]       addr_rc_rd_odd,
    output logic [REG_ADDR_WIDTH-1:0]       rf_addr_rt_wt_even,
    output logic [REG_ADDR_WIDTH-1:0]       rf_addr_rt_wt_odd,
    output logic [15:0]                     stall_cnt,
    output logic [1:0]                      dbg_state
);
    localparam int               NREG    = 2 ** REG_ADDR_WIDTH;
    localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);

    typedef enum logic [1:0] {EMPTY = 2'd0, PAIR = 2'd1, SECOND = 2'd2} state_t;

    typedef struct packed {
        logic                            pipe;
        logic [INTERNAL_OPCODE_SIZE-1:0] opc;
        logic [REG_ADDR_WIDTH-1:0]       ra;
        logic [REG_ADDR_WIDTH-1:0]       rb;
        logic [REG_ADDR_WIDTH-1:0]       rc;
        logic [REG_ADDR_WIDTH-1:0]       rt;
        logic [2:0]                      uses;
        logic                            we;
        logic [LAT_W-1:0]                lat;
    } slot_t;

    state_t           state;
    slot_t            s0, s1, in0, in1, ev, od;
    logic [LAT_W-1:0] sb [NREG];
    logic             haz0, haz1, raw01, pair_ok, iss0, iss1, ld_e, ld_o;

    assign in0 = '{pipe: dec.s0_pipe, opc: dec.s0_opcode, ra: dec.s0_ra, rb: dec.s0_rb,
                   rc: dec.s0_rc, rt: dec.s0_rt, uses: dec.s0_use, we: dec.s0_rt_we, lat: dec.s0_lat};
    assign in1 = '{pipe: dec.s1_pipe, opc: dec.s1_opcode, ra: dec.s1_ra, rb: dec.s1_rb,
                   rc: dec.s1_rc, rt: dec.s1_rt, uses: dec.s1_use, we: dec.s1_rt_we, lat: dec.s1_lat};

    assign dec.in_ready = (state == EMPTY);
    assign dbg_state    = state;

    // A count of 1 expires at this edge, so an instruction issuing at it already sees the result.
    assign haz0 = (s0.opc != '0) &&
                  ((s0.uses[2] && sb[s0.ra] > LAT_ONE) || (s0.uses[1] && sb[s0.rb] > LAT_ONE) ||
                   (s0.uses[0] && sb[s0.rc] > LAT_ONE) || (s0.we && sb[s0.rt] > s0.lat));
    assign haz1 = (s1.opc != '0) &&
                  ((s1.uses[2] && sb[s1.ra] > LAT_ONE) || (s1.uses[1] && sb[s1.rb] > LAT_ONE) ||
                   (s1.uses[0] && sb[s1.rc] > LAT_ONE) || (s1.we && sb[s1.rt] > s1.lat));
    assign raw01 = (s0.opc != '0) && s0.we &&
                   ((s1.uses[2] && s1.ra == s0.rt) || (s1.uses[1] && s1.rb == s0.rt) ||
                    (s1.uses[0] && s1.rc == s0.rt));

`ifdef SPU_DUAL_ISSUE_EN
    assign pair_ok = (s1.opc == '0) ||
                     (((s0.opc == '0) || (s0.pipe != s1.pipe)) && !haz1 && !raw01);
`else
    assign pair_ok = (s1.opc == '0);
`endif

    always_comb begin
        iss0 = 1'b0;
        iss1 = 1'b0;
        ev   = '0;
        od   = '0;
        if (!flush) begin
            case (state)
                PAIR: begin
                    iss0 = !haz0;
                    iss1 = iss0 && pair_ok;
                end
                SECOND:  iss1 = !haz1;
                default: ;
            endcase
        end
        // Empty slots count as issued but never occupy a pipe.
        if (iss0 && s0.opc != '0) begin
            if (s0.pipe) od = s0;
            else         ev = s0;
        end
        if (iss1 && s1.opc != '0) begin
            if (s1.pipe) od = s1;
            else         ev = s1;
        end
        ld_e = (ev.opc != '0) && ev.we;
        ld_o = (od.opc != '0) && od.we;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= EMPTY;
            s0                 <= '0;
            s1                 <= '0;
            stall_cnt          <= '0;
            rf_opcode_even     <= '0;
            rf_opcode_odd      <= '0;
            addr_ra_rd_even    <= '0;
            addr_ra_rd_odd     <= '0;
            addr_rb_rd_even    <= '0;
            addr_rb_rd_odd     <= '0;
            addr_rc_rd_even    <= '0;
            addr_rc_rd_odd     <= '0;
            rf_addr_rt_wt_even <= '0;
            rf_addr_rt_wt_odd  <= '0;
            for (int i = 0; i < NREG; i++) sb[i] <= '0;
        end else begin
            rf_opcode_even     <= ev.opc;
            rf_opcode_odd      <= od.opc;
            addr_ra_rd_even    <= ev.ra;
            addr_ra_rd_odd     <= od.ra;
            addr_rb_rd_even    <= ev.rb;
            addr_rb_rd_odd     <= od.rb;
            addr_rc_rd_even    <= ev.rc;
            addr_rc_rd_odd     <= od.rc;
            rf_addr_rt_wt_even <= ev.rt;
            rf_addr_rt_wt_odd  <= od.rt;

            if (state != EMPTY && !iss0 && !iss1 && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;

            if (flush) begin
                state <= EMPTY;
            end else begin
                case (state)
                    EMPTY: if (dec.in_valid) begin
                        s0    <= in0;
                        s1    <= in1;
                        state <= PAIR;
                    end
                    PAIR: begin
                        if (iss0 && iss1) state <= EMPTY;
                        else if (iss0)    state <= SECOND;
                    end
                    SECOND: if (iss1) state <= EMPTY;
                    default: state <= EMPTY;
                endcase
            end

            // Issue loads beat the decrement; a same-register double write keeps the longer latency.
            for (int i = 0; i < NREG; i++) begin
                if (ld_e && ev.rt == REG_ADDR_WIDTH'(i) &&
                    !(ld_o && od.rt == REG_ADDR_WIDTH'(i) && od.lat > ev.lat))
                    sb[i] <= ev.lat;
                else if (ld_o && od.rt == REG_ADDR_WIDTH'(i))
                    sb[i] <= od.lat;
                else if (sb[i] != '0)
                    sb[i] <= sb[i] - LAT_ONE;
            end
        end
    end
endmodule
